spike_event_encoder: RTL and testbench

- Sits directly downstream of the spiking network's output layer.
- Consumes the single-cycle spike pulses of the output neurons and tags each with a free-running timestamp.
- Buffers events in a small FIFO and streams them out byte-serially over a valid/ready interface, for the pad-limited top level or an off-chip logger.
- Converts level/pulse spike activity into an ordered, loss-flagged event stream.

---
 rtl/spike_event_encoder.sv | 164 ++++++++++++++++
 tb/tb_spike_event_encoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_encoder.sv
// Spike event encoder: timestamps output-layer spike pulses, queues them in a small FIFO
// and streams each 16-bit event {ch_id, ts} out as two bytes over valid/ready.
module spike_event_encoder #(
  parameter int NUM_CH     = 2,
  parameter int TS_WIDTH   = 14,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] spike_in,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        fifo_count,
  output logic              overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH_CNT = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;

  logic [TS_WIDTH-1:0] ts;
  logic [NUM_CH-1:0]   pending;
  logic [TS_WIDTH-1:0] ts_hold [NUM_CH];
  logic [15:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [3:0]          count;
  state_t              state;
  logic [15:0]         shift;

  logic                full;
  logic                nonempty;
  logic                grant_vld;
  logic [1:0]          grant_idx;
  logic [TS_WIDTH-1:0] grant_ts;
  logic [NUM_CH-1:0]   clear;
  logic [NUM_CH-1:0]   capture;
  logic [NUM_CH-1:0]   drop;
  logic                fifo_wr;
  logic                fifo_pop;
  logic [15:0]         head;

  assign full     = (count == DEPTH_CNT);
  assign nonempty = (count != 4'd0);
  assign head     = mem[rd_ptr];
  assign fifo_wr  = grant_vld;
  assign fifo_pop = nonempty && ((state == IDLE) || (state == SEND_LO && out_ready));

  // Lowest-numbered pending channel wins; a full FIFO simply leaves everything pending.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    grant_ts  = '0;
    clear     = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pending[c]) begin
        grant_idx = 2'(c);
        grant_ts  = ts_hold[c];
      end
    end
    if (|pending && !full) begin
      grant_vld            = 1'b1;
      clear[grant_idx]     = 1'b1;
    end
  end

  // A repeat spike is only lost if its channel is still pending after this edge.
  always_comb begin
    capture = '0;
    drop    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (en && spike_in[c]) begin
        if (pending[c] && !clear[c]) drop[c] = 1'b1;
        else                         capture[c] = 1'b1;
      end
    end
  end

  // Capture / arbitration control
  always_ff @(posedge clk) begin
    if (rst) begin
      ts       <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      if (en) ts <= ts + TS_WIDTH'(1);
      pending <= (pending & ~clear) | capture;
      if (|drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (capture[c]) ts_hold[c] <= ts;
    end
    if (fifo_wr) mem[wr_ptr] <= {grant_idx, grant_ts};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr)  wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_wr, fifo_pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  assign fifo_count = count;

  // Byte serializer: high byte, then low byte, back-to-back when more events wait
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_byte  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            shift     <= head;
            out_byte  <= head[15:8];
            out_valid <= 1'b1;
            state     <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (out_ready) begin
            out_byte <= shift[7:0];
            state    <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (out_ready) begin
            if (fifo_pop) begin
              shift    <= head;
              out_byte <= head[15:8];
              state    <= SEND_HI;
            end else begin
              out_valid <= 1'b0;
              out_byte  <= 8'd0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Randomized and directed bench for spike_event_encoder against an event-queue reference model.
module tb_spike_event_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] spike_in;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] fifo_count;
  logic       overflow;

  spike_event_encoder #(.NUM_CH(2), .TS_WIDTH(14), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: event queue, in-flight event, per-channel pending spike.
  int m_ts;
  bit m_pend [2];
  int m_hold [2];
  int q [$];
  bit m_busy;
  bit m_lo;
  int m_cur;
  bit m_ovf;
  int m_events;
  int obs [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_ts = 0; m_pend[0] = 0; m_pend[1] = 0; q.delete();
    m_busy = 0; m_lo = 0; m_cur = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit e, input bit [1:0] s, input bit rd);
    int sz;
    sz = q.size();
    if (m_busy && rd && !m_lo) m_lo = 1;
    else if (!m_busy || (rd && m_lo)) begin
      if (sz > 0) begin
        m_cur = q.pop_front(); m_busy = 1; m_lo = 0;
      end else begin
        m_busy = 0; m_lo = 0;
      end
    end
    if (sz < 8) begin
      for (int c = 0; c < 2; c++) begin
        if (m_pend[c]) begin
          q.push_back(c * 16384 + m_hold[c]);
          m_pend[c] = 0;
          break;
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (e && s[c]) begin
        if (m_pend[c]) m_ovf = 1;
        else begin m_pend[c] = 1; m_hold[c] = m_ts; m_events++; end
      end
    end
    if (e) m_ts = (m_ts + 1) % 16384;
  endtask

  task automatic step(input bit r, input bit e, input bit [1:0] s, input bit rd);
    int exp_byte;
    rst = r; en = e; spike_in = s; out_ready = rd;
    if (!r && out_valid && rd) obs.push_back(int'(out_byte));
    @(posedge clk);
    if (r) model_reset();
    else   model_edge(e, s, rd);
    #1;
    exp_byte = !m_busy ? 0 : (m_lo ? (m_cur & 8'hFF) : (m_cur >> 8));
    chk("out_valid", 32'(out_valid), 32'(m_busy));
    chk("out_byte", 32'(out_byte), 32'(exp_byte));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n, input bit e, input bit rd);
    for (int i = 0; i < n; i++) step(0, e, 2'b00, rd);
  endtask

  int peak;
  int prev_ts;

  initial begin
    rst = 1; en = 0; spike_in = 0; out_ready = 0;
    m_events = 0;
    model_reset();

    // Reset state and basic latency
    step(1, 0, 2'b00, 1);
    step(1, 0, 2'b00, 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    idle(5, 1, 1);
    step(0, 1, 2'b01, 1);
    step(0, 1, 2'b00, 1);
    step(0, 1, 2'b00, 1);
    chk("lat_hi_valid", 32'(out_valid), 1);
    chk("lat_hi_byte", 32'(out_byte), 32'h00);
    step(0, 1, 2'b00, 1);
    chk("lat_lo_byte", 32'(out_byte), 32'h05);
    step(0, 1, 2'b00, 1);
    chk("lat_end_valid", 32'(out_valid), 0);
    chk("lat_overflow", 32'(overflow), 0);

    // Simultaneous spikes on both channels
    step(1, 0, 2'b00, 1);
    idle(32'h1234, 1, 1);
    obs.delete();
    peak = 0;
    step(0, 1, 2'b11, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 2'b00, 1);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    chk("dual_peak", 32'(peak), 1);
    chk("dual_nbytes", 32'(obs.size()), 4);
    if (obs.size() == 4) begin
      chk("dual_b0", 32'(obs[0]), 32'h12);
      chk("dual_b1", 32'(obs[1]), 32'h34);
      chk("dual_b2", 32'(obs[2]), 32'h52);
      chk("dual_b3", 32'(obs[3]), 32'h34);
    end

    // Backpressure fill, overflow, then drain in order
    step(1, 0, 2'b00, 0);
    m_events = 0;
    obs.delete();
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 2'b10, 0);
      step(0, 1, 2'b00, 0);
    end
    chk("bp_full", 32'(fifo_count), 8);
    chk("bp_overflow", 32'(overflow), 1);
    idle(40, 1, 1);
    chk("bp_drained", 32'(fifo_count), 0);
    chk("bp_nbytes", 32'(obs.size()), 32'(2 * m_events));
    prev_ts = -1;
    for (int i = 0; i + 1 < obs.size(); i += 2) begin
      int w;
      w = obs[i] * 256 + obs[i + 1];
      if ((w & 16'h3FFF) <= prev_ts) chk("bp_order", 32'(w & 16'h3FFF), 32'(prev_ts + 1));
      prev_ts = w & 16'h3FFF;
    end

    // Timestamp wrap
    step(1, 0, 2'b00, 1);
    idle(16383, 1, 1);
    obs.delete();
    step(0, 1, 2'b01, 1);
    step(0, 1, 2'b01, 1);
    idle(10, 1, 1);
    chk("wrap_nbytes", 32'(obs.size()), 4);
    if (obs.size() == 4) begin
      chk("wrap_w0", 32'(obs[0] * 256 + obs[1]), 32'h3FFF);
      chk("wrap_w1", 32'(obs[2] * 256 + obs[3]), 32'h0000);
    end

    // Randomized spikes, enable and backpressure
    step(1, 0, 2'b00, 1);
    for (int i = 0; i < 3000; i++) begin
      step(0, ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3) & $urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
    end
    idle(40, 1, 1);

    // Reset in the middle of a low-byte transfer with events queued
    step(1, 0, 2'b00, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2'b11, 0);
      step(0, 1, 2'b00, 0);
    end
    step(0, 1, 2'b00, 1);
    chk("mid_queued", 32'(fifo_count >= 4'd3), 1);
    step(1, 1, 2'b11, 0);
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_count", 32'(fifo_count), 0);
    chk("mid_overflow", 32'(overflow), 0);
    obs.delete();
    step(0, 1, 2'b01, 1);
    idle(6, 1, 1);
    chk("mid_nbytes", 32'(obs.size()), 2);
    if (obs.size() == 2) chk("mid_ts0", 32'(obs[0] * 256 + obs[1]), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
